// File: rtl/pc_fetch_sequencer_pkg.sv
// Shared types and default constants for the PC fetch sequencer.
package pc_fetch_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_FETCH = 2'd1,
      ST_ISSUE = 2'd2
   } fetch_state_e;

   localparam int DEF_ADDR_W   = 8;
   localparam int DEF_DATA_W   = 8;
   localparam int DEF_PC_STEP  = 4;
   localparam int DEF_RESET_PC = 0;

endpackage

// File: rtl/pc_fetch_sequencer_if.sv
// Instruction-memory req/ack port plus decoder valid/ready port of the fetch sequencer.
interface pc_fetch_sequencer_if #(
   parameter int ADDR_W = 8,
   parameter int DATA_W = 8
) ();

   logic              imem_req;
   logic [ADDR_W-1:0] imem_addr;
   logic              imem_ack;
   logic [DATA_W-1:0] imem_rdata;
   logic              instr_valid;
   logic [DATA_W-1:0] instr_data;
   logic [ADDR_W-1:0] instr_pc;
   logic              instr_ready;

   modport master (
      output imem_req, imem_addr, instr_valid, instr_data, instr_pc,
      input  imem_ack, imem_rdata, instr_ready
   );

   modport slave (
      input  imem_req, imem_addr, instr_valid, instr_data, instr_pc,
      output imem_ack, imem_rdata, instr_ready
   );

endinterface

// File: rtl/pc_fetch_sequencer_pc_reg.sv
// Program counter register: hold, step by PC_STEP, or load; load has priority over step.
module pc_reg #(
   parameter int ADDR_W   = 8,
   parameter int PC_STEP  = 4,
   parameter int RESET_PC = 0
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              load_i,
   input  logic [ADDR_W-1:0] load_addr_i,
   input  logic              step_i,
   output logic [ADDR_W-1:0] pc_o
);

   logic [ADDR_W-1:0] pc_q;

   // Step wraps modulo 2^ADDR_W by plain truncation.
   always_ff @(posedge clk) begin
      if (!rst_n)      pc_q <= ADDR_W'(RESET_PC);
      else if (load_i) pc_q <= load_addr_i;
      else if (step_i) pc_q <= pc_q + ADDR_W'(PC_STEP);
   end

   assign pc_o = pc_q;

endmodule

// File: rtl/pc_fetch_sequencer.sv
// Fetch controller: owns the PC, fetches over req/ack and issues words over valid/ready.
// Optional FETCH_TIMEOUT_EN: abort a fetch after TIMEOUT_CYC ack-less cycles, sticky fetch_err_o.
module pc_fetch_sequencer
   import pc_fetch_pkg::*;
#(
   parameter int ADDR_W   = DEF_ADDR_W,
   parameter int DATA_W   = DEF_DATA_W,
   parameter int PC_STEP  = DEF_PC_STEP,
   parameter int RESET_PC = DEF_RESET_PC
`ifdef FETCH_TIMEOUT_EN
  ,parameter int TIMEOUT_CYC = 15
`endif
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 start_i,
   input  logic                 halt_i,
   input  logic                 redirect_valid_i,
   input  logic [ADDR_W-1:0]    redirect_addr_i,
   pc_fetch_sequencer_if.master bus,
   output logic                 busy_o,
   output logic                 fetch_err_o
);

   fetch_state_e      state_q;
   logic              imem_req_q;
   logic              instr_valid_q;
   logic              halt_pend_q;
   logic [DATA_W-1:0] instr_data_q;
   logic [ADDR_W-1:0] instr_pc_q;
   logic [ADDR_W-1:0] pc;
   logic              halt_now;
   logic              pc_step;

`ifdef FETCH_TIMEOUT_EN
   localparam int TO_W = $clog2(TIMEOUT_CYC + 1);
   logic [TO_W-1:0] to_cnt_q;
   logic            err_q;
`endif

   // A halt seen at any point during a fetch is remembered until the word is issued.
   assign halt_now = halt_i | halt_pend_q;
   assign pc_step  = (state_q == ST_FETCH) & bus.imem_ack;

   pc_reg #(
      .ADDR_W   (ADDR_W),
      .PC_STEP  (PC_STEP),
      .RESET_PC (RESET_PC)
   ) u_pc (
      .clk         (clk),
      .rst_n       (rst_n),
      .load_i      (redirect_valid_i),
      .load_addr_i (redirect_addr_i),
      .step_i      (pc_step),
      .pc_o        (pc)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q       <= ST_IDLE;
         imem_req_q    <= 1'b0;
         instr_valid_q <= 1'b0;
         halt_pend_q   <= 1'b0;
         instr_data_q  <= '0;
         instr_pc_q    <= '0;
`ifdef FETCH_TIMEOUT_EN
         to_cnt_q      <= '0;
         err_q         <= 1'b0;
`endif
      end else begin
         halt_pend_q <= halt_now;
`ifdef FETCH_TIMEOUT_EN
         to_cnt_q    <= '0;
`endif
         case (state_q)
            ST_IDLE: begin
               halt_pend_q <= 1'b0;
               if (start_i) begin
                  state_q    <= ST_FETCH;
                  imem_req_q <= 1'b1;
               end
            end
            ST_FETCH: begin
               // Redirect beats a same-cycle ack; the returned word is dropped.
               if (redirect_valid_i) begin
                  if (halt_now) begin
                     state_q     <= ST_IDLE;
                     imem_req_q  <= 1'b0;
                     halt_pend_q <= 1'b0;
                  end
               end else if (bus.imem_ack) begin
                  state_q       <= ST_ISSUE;
                  imem_req_q    <= 1'b0;
                  instr_valid_q <= 1'b1;
                  instr_data_q  <= bus.imem_rdata;
                  instr_pc_q    <= pc;
               end
`ifdef FETCH_TIMEOUT_EN
               else if (to_cnt_q == TO_W'(TIMEOUT_CYC - 1)) begin
                  state_q     <= ST_IDLE;
                  imem_req_q  <= 1'b0;
                  halt_pend_q <= 1'b0;
                  err_q       <= 1'b1;
               end else begin
                  to_cnt_q <= to_cnt_q + 1'b1;
               end
`endif
            end
            ST_ISSUE: begin
               if (redirect_valid_i || bus.instr_ready) begin
                  instr_valid_q <= 1'b0;
                  if (halt_now) begin
                     state_q     <= ST_IDLE;
                     halt_pend_q <= 1'b0;
                  end else begin
                     state_q    <= ST_FETCH;
                     imem_req_q <= 1'b1;
                  end
               end
            end
            default: begin
               state_q       <= ST_IDLE;
               imem_req_q    <= 1'b0;
               instr_valid_q <= 1'b0;
            end
         endcase
      end
   end

   assign bus.imem_req    = imem_req_q;
   assign bus.imem_addr   = pc;
   assign bus.instr_valid = instr_valid_q;
   assign bus.instr_data  = instr_data_q;
   assign bus.instr_pc    = instr_pc_q;
   assign busy_o          = (state_q != ST_IDLE);

`ifdef FETCH_TIMEOUT_EN
   assign fetch_err_o = err_q;
`else
   assign fetch_err_o = 1'b0;
`endif

endmodule

// File: tb/tb_pc_fetch_sequencer.sv
// Scoreboard bench for pc_fetch_sequencer: memory model with settable wait states,
// expected fetch addresses and issued words queued at stimulus time, checked by a monitor.
module tb_pc_fetch_sequencer;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       start = 1'b0;
   logic       halt = 1'b0;
   logic       redir = 1'b0;
   logic [7:0] redir_addr = 8'h00;
   logic       busy;
   logic       ferr;

   pc_fetch_sequencer_if #(.ADDR_W(8), .DATA_W(8)) bus ();

   pc_fetch_sequencer #(
      .ADDR_W(8), .DATA_W(8), .PC_STEP(4), .RESET_PC(0)
   ) dut (
      .clk              (clk),
      .rst_n            (rst_n),
      .start_i          (start),
      .halt_i           (halt),
      .redirect_valid_i (redir),
      .redirect_addr_i  (redir_addr),
      .bus              (bus),
      .busy_o           (busy),
      .fetch_err_o      (ferr)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [7:0] pc;
      logic [7:0] data;
   } exp_t;

   exp_t       sb[$];
   logic [7:0] addr_q[$];
   int         issue_t[$];
   exp_t       mon_e;
   int         n_cmp = 0;
   int         n_err = 0;
   int         issue_cnt = 0;
   int         cyc = 0;
   int         mem_wait = 0;
   int         wcnt = 0;
   bit         mem_en = 1'b1;
   int         n_req;

   function automatic logic [7:0] data_of(logic [7:0] a);
      return 8'hA0 + {2'b00, a[7:2]};
   endfunction

   assign bus.imem_rdata = data_of(bus.imem_addr);

   task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   always @(posedge clk) cyc <= cyc + 1;

   // Memory: acks one cycle after seeing req, plus mem_wait extra cycles.
   always @(posedge clk) begin
      if (!rst_n) begin
         bus.imem_ack <= 1'b0;
         wcnt         <= 0;
      end else if (mem_en && bus.imem_req && !bus.imem_ack) begin
         if (wcnt >= mem_wait) begin
            bus.imem_ack <= 1'b1;
            wcnt         <= 0;
         end else begin
            wcnt <= wcnt + 1;
         end
      end else begin
         bus.imem_ack <= 1'b0;
      end
   end

   always @(negedge clk) begin
      if (rst_n) begin
         if (bus.imem_req && bus.imem_ack) begin
            if (addr_q.size() == 0) chk("fetch_unexp", 32'(addr_q.size()), 32'd1);
            else chk("fetch_addr", 32'(bus.imem_addr), 32'(addr_q.pop_front()));
         end
         if (bus.instr_valid && bus.instr_ready) begin
            issue_cnt++;
            issue_t.push_back(cyc);
            if (sb.size() == 0) chk("issue_unexp", 32'(sb.size()), 32'd1);
            else begin
               mon_e = sb.pop_front();
               chk("issue_pc", 32'(bus.instr_pc), 32'(mon_e.pc));
               chk("issue_data", 32'(bus.instr_data), 32'(mon_e.data));
            end
         end
      end
   end

   task automatic step(int n = 1);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic pulse_start();
      start = 1'b1;
      step();
      start = 1'b0;
   endtask

   task automatic expect_fetch(logic [7:0] a, bit issued);
      exp_t e;
      addr_q.push_back(a);
      if (issued) begin
         e.pc   = a;
         e.data = data_of(a);
         sb.push_back(e);
      end
   endtask

   task automatic wait_issue(int n);
      for (int i = 0; i < 200 && issue_cnt < n; i++) step();
      if (issue_cnt < n) chk("wait_issue", 32'(issue_cnt), 32'(n));
   endtask

   task automatic wait_valid(logic v);
      for (int i = 0; i < 200 && bus.instr_valid !== v; i++) step();
      if (bus.instr_valid !== v) chk("wait_valid", 32'(bus.instr_valid), 32'(v));
   endtask

   task automatic wait_idle();
      for (int i = 0; i < 200 && busy; i++) step();
      if (busy) chk("wait_idle", 32'(busy), 32'd0);
   endtask

   task automatic check_reset_state(string tag);
      chk({tag, "_busy"}, 32'(busy), 32'd0);
      chk({tag, "_req"}, 32'(bus.imem_req), 32'd0);
      chk({tag, "_addr"}, 32'(bus.imem_addr), 32'h00);
      chk({tag, "_valid"}, 32'(bus.instr_valid), 32'd0);
      chk({tag, "_data"}, 32'(bus.instr_data), 32'h00);
      chk({tag, "_ipc"}, 32'(bus.instr_pc), 32'h00);
      chk({tag, "_err"}, 32'(ferr), 32'd0);
   endtask

   initial begin
      bus.instr_ready = 1'b1;
      step(3);
      check_reset_state("rst");
      rst_n = 1'b1;
      step();

      // Streaming: three words back to back, halt lands in the third fetch.
      expect_fetch(8'h00, 1'b1);
      expect_fetch(8'h04, 1'b1);
      expect_fetch(8'h08, 1'b1);
      pulse_start();
      wait_issue(2);
      wait_valid(1'b0);
      halt = 1'b1;
      wait_issue(3);
      wait_idle();
      halt = 1'b0;
      chk("gap1", 32'(issue_t[1] - issue_t[0]), 32'd3);
      chk("gap2", 32'(issue_t[2] - issue_t[1]), 32'd3);
      chk("idle_req", 32'(bus.imem_req), 32'd0);
      chk("idle_pc", 32'(bus.imem_addr), 32'h0C);

      // Slow memory: request and address must hold through the wait states.
      mem_wait = 5;
      halt = 1'b1;
      expect_fetch(8'h0C, 1'b1);
      pulse_start();
      for (int i = 0; i < 5; i++) begin
         chk("wait_req", 32'(bus.imem_req), 32'd1);
         chk("wait_addr", 32'(bus.imem_addr), 32'h0C);
         chk("wait_noack", 32'(bus.imem_ack), 32'd0);
         step();
      end
      wait_issue(4);
      wait_idle();
      halt = 1'b0;
      mem_wait = 0;
      step(3);
      chk("single_issue", 32'(issue_cnt), 32'd4);

      // Decoder stall: word held, no new request until accepted.
      bus.instr_ready = 1'b0;
      expect_fetch(8'h10, 1'b1);
      expect_fetch(8'h14, 1'b1);
      pulse_start();
      wait_valid(1'b1);
      for (int i = 0; i < 4; i++) begin
         chk("stall_valid", 32'(bus.instr_valid), 32'd1);
         chk("stall_data", 32'(bus.instr_data), 32'hA4);
         chk("stall_pc", 32'(bus.instr_pc), 32'h10);
         chk("stall_noreq", 32'(bus.imem_req), 32'd0);
         step();
      end
      bus.instr_ready = 1'b1;
      wait_issue(5);
      wait_valid(1'b0);
      halt = 1'b1;
      wait_issue(6);
      wait_idle();
      halt = 1'b0;

      // Redirect on the ack cycle: word at 0x18 is dropped, fetch restarts at 0x40.
      expect_fetch(8'h18, 1'b0);
      expect_fetch(8'h40, 1'b1);
      pulse_start();
      for (int i = 0; i < 50 && !bus.imem_ack; i++) step();
      chk("saw_ack", 32'(bus.imem_ack), 32'd1);
      redir = 1'b1;
      redir_addr = 8'h40;
      step();
      redir = 1'b0;
      chk("redir_addr", 32'(bus.imem_addr), 32'h40);
      chk("redir_req", 32'(bus.imem_req), 32'd1);
      chk("redir_novalid", 32'(bus.instr_valid), 32'd0);
      halt = 1'b1;
      wait_issue(7);
      wait_idle();
      halt = 1'b0;
      chk("redir_next_pc", 32'(bus.imem_addr), 32'h44);

      // Redirect in IDLE only loads the PC; then fetch across the wrap.
      redir = 1'b1;
      redir_addr = 8'hFC;
      step();
      redir = 1'b0;
      chk("idle_redir_busy", 32'(busy), 32'd0);
      chk("idle_redir_pc", 32'(bus.imem_addr), 32'hFC);
      expect_fetch(8'hFC, 1'b1);
      expect_fetch(8'h00, 1'b1);
      pulse_start();
      wait_issue(8);
      wait_valid(1'b0);
      halt = 1'b1;
      wait_issue(9);
      wait_idle();
      halt = 1'b0;
      chk("wrap_pc", 32'(bus.imem_addr), 32'h04);

      // Redirect together with halt while a word waits: PC loaded, word dropped, IDLE.
      bus.instr_ready = 1'b0;
      expect_fetch(8'h04, 1'b0);
      pulse_start();
      wait_valid(1'b1);
      chk("pend_pc", 32'(bus.instr_pc), 32'h04);
      redir = 1'b1;
      redir_addr = 8'h80;
      halt = 1'b1;
      step();
      redir = 1'b0;
      halt = 1'b0;
      bus.instr_ready = 1'b1;
      chk("rh_busy", 32'(busy), 32'd0);
      chk("rh_valid", 32'(bus.instr_valid), 32'd0);
      chk("rh_addr", 32'(bus.imem_addr), 32'h80);
      chk("rh_req", 32'(bus.imem_req), 32'd0);
      step(2);
      chk("total_issued", 32'(issue_cnt), 32'd9);
      chk("sb_left", 32'(sb.size()), 32'd0);
      chk("addr_left", 32'(addr_q.size()), 32'd0);

      // Memory that never answers.
      mem_en = 1'b0;
`ifdef FETCH_TIMEOUT_EN
      pulse_start();
      n_req = 0;
      for (int i = 0; i < 40 && bus.imem_req; i++) begin
         n_req++;
         step();
      end
      chk("to_req_cycles", 32'(n_req), 32'd15);
      chk("to_err", 32'(ferr), 32'd1);
      chk("to_busy", 32'(busy), 32'd0);
      chk("to_pc_kept", 32'(bus.imem_addr), 32'h80);
      pulse_start();
      chk("to_err_sticky", 32'(ferr), 32'd1);
      chk("to_restart_req", 32'(bus.imem_req), 32'd1);
`else
      pulse_start();
      step(30);
      chk("hang_req", 32'(bus.imem_req), 32'd1);
      chk("hang_busy", 32'(busy), 32'd1);
      chk("hang_addr", 32'(bus.imem_addr), 32'h80);
      chk("hang_err", 32'(ferr), 32'd0);
`endif
      rst_n = 1'b0;
      step();
      check_reset_state("midrst");
      rst_n = 1'b1;
      mem_en = 1'b1;
      step(2);
      chk("post_rst_busy", 32'(busy), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
